fusion_psum_accum: RTL and testbench
====================================

Name: fusion_psum_accum

Overview:
- Sits directly downstream of the fusion unit and consumes its registered 18-bit psum_fwd.
- Accumulates acc_len consecutive psums into a wide partial sum. Two modes: one 18-bit total, or two independent 9-bit column lanes {col2,col1}.
- Emits the finished sum through a one-entry valid/ready output register toward the next array stage or the writeback stage.

Parameters:
- PSUM_W, 18, input psum width. Must be even; a lane is PSUM_W/2.
- ACC_W, 32, accumulator width. Must be even; a split-mode lane is ACC_W/2.
- LEN_W, 8, width of acc_len.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- psum_in  in  PSUM_W  psum from the fusion unit
- in_valid  in  1  psum_in is valid this cycle
- in_ready  out  1  accumulator accepts psum_in this cycle
- split_mode  in  1  1: two lanes {hi,lo}; 0: one total
- s_mode  in  1  1: signed extension (s_in|s_weight); 0: unsigned
- acc_len  in  LEN_W  number of psums per output, 0 treated as 1
- out_sum  out  ACC_W  result; in split mode {lane_hi, lane_lo}, ACC_W/2 bits each
- out_valid  out  1  out_sum holds a finished result
- out_ready  in  1  consumer accepts out_sum
- out_split  out  1  split_mode captured for the result in out_sum

Behaviour:
- Reset: rst=1 at posedge clears acc, cnt, out_sum, out_valid, out_split and state to 0/IDLE. Reset mid-group discards the partial sum and any held output. in_ready=0 while rst=1.
- States:
  - IDLE: acc=0, cnt=0.
  - ACCUM: group in progress.
  - FULL: group complete but the output register is occupied.
- Beat accepted = in_valid & in_ready.
- First beat of a group, taken in IDLE:
  - Latch split_mode, s_mode and len=max(acc_len,1).
  - Changes to these inputs mid-group are ignored.
- Extension:
  - Total mode: sign- or zero-extend psum_in from PSUM_W to ACC_W, per latched s_mode.
  - Split mode: extend each PSUM_W/2 lane to ACC_W/2 independently.
  - No carry crosses between lanes.
- Per beat: acc += ext(psum_in); cnt += 1. The add is wrap-around unless SATURATE_EN is defined.
- Group completes on the beat where cnt+1==len. The final value includes that beat.
  - If the output register is empty, or out_ready=1 this cycle: load out_sum/out_split, set out_valid=1 the next cycle, return to IDLE. A new group may start on the following cycle.
  - Otherwise go to FULL with the result held in acc.
- FULL: in_ready=0. On the cycle out_ready=1, transfer acc to out_sum, then go to IDLE.
- in_ready = (state != FULL) & ~rst.
- Latency: out_valid rises 1 cycle after the last accepted beat when no backpressure applies.
- Throughput: one psum per cycle. When len=1 and out_ready is held at 1, results stream back-to-back.
- Output register: out_valid drops after a handshake (out_valid & out_ready) unless a new result loads in the same cycle. A simultaneous load and pop leaves out_valid=1 with the new data.
- in_valid=0 mid-group stalls the group; acc and cnt hold.

Optional Feature:
- FUSION_ACCUM_SATURATE_EN defined:
  - Each add saturates per lane (split) or per word (total).
  - Signed range is [-2^(W-1), 2^(W-1)-1]; unsigned range is [0, 2^W-1].
  - Saturation is sticky for the rest of the group, and an extra output sat_flag marks a saturated result.
- Macro undefined: modular wrap, and no sat_flag port.

Decomposition:
- Shared package fusion_pkg holds:
  - state enum {IDLE, ACCUM, FULL};
  - PSUM_W and ACC_W defaults;
  - the lane-width function W/2.
- One sub-module, fusion_lane_add: a one-lane extend-and-add with width, signed and optional saturation parameters. It is instantiated twice for the two halves; total mode chains the carry from the lo instance into the hi instance.

Test Plan:
- Total unsigned, len=3, psums 100,200,300, out_ready=1 -> out_sum=600, out_valid exactly 1 cycle after 3rd beat.
- Total signed, len=2, psums 18'h3FFFF(-1),18'h3FFFE(-2) -> out_sum=32'hFFFFFFFD.
- Split signed, len=2, psum {9'h1FF,9'h002} twice -> lane_hi=16'hFFFE, lane_lo=16'h0004, out_split=1, no cross-lane carry.
- Backpressure: len=1, out_ready=0, 2 beats -> 2nd result held in FULL, in_ready=0; out_ready=1 for 1 cycle -> 1st popped, 2nd loaded, in_ready=1 next cycle.
- rst asserted after 2 of 4 beats -> out_valid=0, next group len=1 psum 5 -> out_sum=5.
- SATURATE_EN, unsigned total, ACC_W=20, psums 18'h3FFFF x8 -> out_sum=20'hFFFFF, sat_flag=1.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared types and defaults for the fusion psum accumulator slice.
package fusion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int PSUM_W_DEF = 18;
  localparam int ACC_W_DEF  = 32;

  function automatic int lane_w(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/fusion_lane_add.sv
// One accumulator lane: acc + addend + carry-in, optionally clamped on overflow.
// Total mode chains two of these through cin/cout; split mode runs them independently.
module fusion_lane_add #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         cin,
  input  logic         is_signed,
  input  logic         clamp_en,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         sat_neg
);

  logic [W:0]   raw_s;
  logic         sovf_s;
  logic [W-1:0] sat_val_s;

  assign raw_s   = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, cin};
  assign cout    = raw_s[W];
  // Two same-sign operands giving a result of the other sign is signed overflow.
  assign sovf_s  = (acc[W-1] == addend[W-1]) && (raw_s[W-1] != acc[W-1]);
  assign ovf     = SAT & clamp_en & (is_signed ? sovf_s : raw_s[W]);
  assign sat_neg = is_signed & addend[W-1];

  // Clamp value: signed min/max by direction of overflow, unsigned only overflows upward.
  always_comb begin
    sat_val_s = '1;
    if (is_signed) begin
      sat_val_s = sat_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat_val_s = '1;
    end
  end

  assign sum = ovf ? sat_val_s : raw_s[W-1:0];

endmodule

// File: rtl/fusion_psum_accum.sv
// Accumulates acc_len fusion psums (one total or two column lanes) into a valid/ready output register.
// Optional clamping arithmetic and sat_flag port: define FUSION_ACCUM_SATURATE_EN.
module fusion_psum_accum
  import fusion_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              split_mode,
  input  logic              s_mode,
  input  logic [LEN_W-1:0]  acc_len,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_split
`ifdef FUSION_ACCUM_SATURATE_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int LW  = lane_w(ACC_W);
  localparam int PLW = lane_w(PSUM_W);
`ifdef FUSION_ACCUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] len_r;
  logic             split_r;
  logic             sgn_r;
  logic [1:0]       sat_r;
  logic             sat_out_r;

  logic             idle_s;
  logic             split_s;
  logic             sgn_s;
  logic [LEN_W-1:0] len_s;
  logic [LEN_W-1:0] cnt_inc_s;
  logic             beat_s;
  logic             last_s;
  logic             out_free_s;

  logic [ACC_W-1:0] ext_tot_s;
  logic [LW-1:0]    ext_lo_s;
  logic [LW-1:0]    ext_hi_s;
  logic [LW-1:0]    add_lo_s;
  logic [LW-1:0]    add_hi_s;
  logic [LW-1:0]    lo_sum_s;
  logic [LW-1:0]    hi_sum_s;
  logic [LW-1:0]    lo_final_s;
  logic             lo_cout_s;
  logic             hi_cout_s;
  logic             lo_ovf_s;
  logic             hi_ovf_s;
  logic             lo_sat_neg_s;
  logic             hi_sat_neg_s;
  logic             lo_hold_s;
  logic [1:0]       sat_next_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             unused_s;

  // The first beat of a group uses the live mode inputs; later beats use the latched copies.
  assign idle_s     = (state_r == IDLE);
  assign split_s    = idle_s ? split_mode : split_r;
  assign sgn_s      = idle_s ? s_mode : sgn_r;
  assign len_s      = idle_s ? ((acc_len == {LEN_W{1'b0}}) ? {{(LEN_W-1){1'b0}}, 1'b1} : acc_len)
                             : len_r;
  assign cnt_inc_s  = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
  assign in_ready   = (state_r != FULL) & ~rst;
  assign beat_s     = in_valid & in_ready;
  assign last_s     = (cnt_inc_s == len_s);
  assign out_free_s = ~out_valid | out_ready;

  assign ext_tot_s = {{(ACC_W-PSUM_W){sgn_s & psum_in[PSUM_W-1]}}, psum_in};
  assign ext_lo_s  = {{(LW-PLW){sgn_s & psum_in[PLW-1]}}, psum_in[PLW-1:0]};
  assign ext_hi_s  = {{(LW-(PSUM_W-PLW)){sgn_s & psum_in[PSUM_W-1]}}, psum_in[PSUM_W-1:PLW]};
  assign add_lo_s  = split_s ? ext_lo_s : ext_tot_s[LW-1:0];
  assign add_hi_s  = split_s ? ext_hi_s : ext_tot_s[ACC_W-1:LW];

  fusion_lane_add #(.W(LW), .SAT(SAT_EN)) u_lane_lo (
    .acc       (acc_r[LW-1:0]),
    .addend    (add_lo_s),
    .cin       (1'b0),
    .is_signed (sgn_s),
    .clamp_en  (split_s),
    .sum       (lo_sum_s),
    .cout      (lo_cout_s),
    .ovf       (lo_ovf_s),
    .sat_neg   (lo_sat_neg_s)
  );

  fusion_lane_add #(.W(LW), .SAT(SAT_EN)) u_lane_hi (
    .acc       (acc_r[ACC_W-1:LW]),
    .addend    (add_hi_s),
    .cin       (~split_s & lo_cout_s),
    .is_signed (sgn_s),
    .clamp_en  (1'b1),
    .sum       (hi_sum_s),
    .cout      (hi_cout_s),
    .ovf       (hi_ovf_s),
    .sat_neg   (hi_sat_neg_s)
  );

  // In total mode a word clamp from the hi lane also fills the lo half.
  assign lo_final_s = (~split_s & hi_ovf_s) ? {LW{~hi_sat_neg_s}} : lo_sum_s;
  assign lo_hold_s  = split_s ? sat_r[0] : sat_r[1];
  assign sat_next_s = sat_r | {hi_ovf_s, lo_ovf_s};
  assign acc_next_s = {sat_r[1] ? acc_r[ACC_W-1:LW] : hi_sum_s,
                       lo_hold_s ? acc_r[LW-1:0] : lo_final_s};

`ifdef FUSION_ACCUM_SATURATE_EN
  assign sat_flag = sat_out_r;
  assign unused_s = &{1'b0, hi_cout_s, lo_sat_neg_s};
`else
  assign unused_s = &{1'b0, hi_cout_s, lo_sat_neg_s, sat_out_r};
`endif

  // Group FSM, accumulator and one-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      cnt_r     <= '0;
      len_r     <= '0;
      split_r   <= 1'b0;
      sgn_r     <= 1'b0;
      sat_r     <= 2'b00;
      sat_out_r <= 1'b0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      out_split <= 1'b0;
    end else begin
      if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_r)
        IDLE, ACCUM: begin
          if (beat_s) begin
            if (idle_s) begin
              split_r <= split_mode;
              sgn_r   <= s_mode;
              len_r   <= len_s;
            end
            if (last_s && out_free_s) begin
              out_sum   <= acc_next_s;
              out_split <= split_s;
              out_valid <= 1'b1;
              sat_out_r <= |sat_next_s;
              acc_r     <= '0;
              cnt_r     <= '0;
              sat_r     <= 2'b00;
              state_r   <= IDLE;
            end else if (last_s) begin
              acc_r   <= acc_next_s;
              sat_r   <= sat_next_s;
              state_r <= FULL;
            end else begin
              acc_r   <= acc_next_s;
              sat_r   <= sat_next_s;
              cnt_r   <= cnt_inc_s;
              state_r <= ACCUM;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_sum   <= acc_r;
            out_split <= split_r;
            out_valid <= 1'b1;
            sat_out_r <= |sat_r;
            acc_r     <= '0;
            cnt_r     <= '0;
            sat_r     <= 2'b00;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_psum_accum.sv
// Directed self-checking bench for fusion_psum_accum (default 18-bit psum, 32-bit accumulator).
module tb_fusion_psum_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] psum_in;
  logic        in_valid;
  logic        in_ready;
  logic        split_mode;
  logic        s_mode;
  logic [7:0]  acc_len;
  logic [31:0] out_sum;
  logic        out_valid;
  logic        out_ready;
  logic        out_split;
`ifdef FUSION_ACCUM_SATURATE_EN
  logic        sat_flag;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fusion_psum_accum dut (
    .clk        (clk),
    .rst        (rst),
    .psum_in    (psum_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .split_mode (split_mode),
    .s_mode     (s_mode),
    .acc_len    (acc_len),
    .out_sum    (out_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_split  (out_split)
`ifdef FUSION_ACCUM_SATURATE_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [17:0] p);
    in_valid = 1'b1;
    psum_in  = p;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; psum_in = 18'd0; in_valid = 1'b0; split_mode = 1'b0;
    s_mode = 1'b0; acc_len = 8'd1; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_split", {31'd0, out_split}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // total unsigned, len 3
    out_ready = 1'b1; split_mode = 1'b0; s_mode = 1'b0; acc_len = 8'd3;
    beat(18'd100);
    check("t1_valid_b1", {31'd0, out_valid}, 32'd0);
    beat(18'd200);
    check("t1_valid_b2", {31'd0, out_valid}, 32'd0);
    beat(18'd300);
    check("t1_valid_b3", {31'd0, out_valid}, 32'd1);
    check("t1_sum", out_sum, 32'd600);
`ifdef FUSION_ACCUM_SATURATE_EN
    check("t1_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif
    idle();
    check("t1_popped", {31'd0, out_valid}, 32'd0);

    // total signed, len 2; mode/len changes mid-group must be ignored
    s_mode = 1'b1; acc_len = 8'd2;
    beat(18'h3FFFF);
    s_mode = 1'b0; acc_len = 8'd5;
    beat(18'h3FFFE);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_sum", out_sum, 32'hFFFFFFFD);
    check("t2_split", {31'd0, out_split}, 32'd0);
    idle();

    // split signed, len 2
    split_mode = 1'b1; s_mode = 1'b1; acc_len = 8'd2;
    beat(18'h3FE02);
    beat(18'h3FE02);
    check("t3_sum", out_sum, 32'hFFFE0004);
    check("t3_split", {31'd0, out_split}, 32'd1);
    idle();

    // split unsigned, lo lane wraps past 16 bits without touching hi
    split_mode = 1'b1; s_mode = 1'b0; acc_len = 8'd200;
    for (int i = 0; i < 200; i++) beat(18'h001FF);
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_no_carry", out_sum, 32'h00008F38);
    idle();

    // acc_len 0 behaves as 1
    split_mode = 1'b0; acc_len = 8'd0;
    beat(18'd7);
    check("t5_len0_valid", {31'd0, out_valid}, 32'd1);
    check("t5_len0_sum", out_sum, 32'd7);
    idle();

    // in_valid gaps stall the group
    acc_len = 8'd3;
    beat(18'd10);
    idle(); idle();
    check("t6_stall_valid", {31'd0, out_valid}, 32'd0);
    beat(18'd20);
    idle();
    beat(18'd30);
    check("t6_sum", out_sum, 32'd60);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    idle();

    // len 1 streaming with out_ready held high
    acc_len = 8'd1;
    beat(18'd1);
    check("t7_s1", out_sum, 32'd1);
    beat(18'd2);
    check("t7_s2", out_sum, 32'd2);
    check("t7_s2_valid", {31'd0, out_valid}, 32'd1);
    beat(18'd3);
    check("t7_s3", out_sum, 32'd3);
    idle();
    check("t7_drain", {31'd0, out_valid}, 32'd0);

    // backpressure: second result parks in FULL
    out_ready = 1'b0;
    beat(18'd11);
    check("t8_first", out_sum, 32'd11);
    check("t8_ready_a", {31'd0, in_ready}, 32'd1);
    beat(18'd22);
    check("t8_full_ready", {31'd0, in_ready}, 32'd0);
    check("t8_held_sum", out_sum, 32'd11);
    idle();
    check("t8_still_full", {31'd0, in_ready}, 32'd0);
    check("t8_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t8_second", out_sum, 32'd22);
    check("t8_second_valid", {31'd0, out_valid}, 32'd1);
    check("t8_ready_back", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("t8_drained", {31'd0, out_valid}, 32'd0);

    // reset mid-group with a held output, then a fresh group
    out_ready = 1'b0; acc_len = 8'd1;
    beat(18'd9);
    acc_len = 8'd4;
    beat(18'd1);
    beat(18'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t9_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t9_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t9_rst_sum", out_sum, 32'd0);
    rst = 1'b0; out_ready = 1'b1; acc_len = 8'd1;
    beat(18'd5);
    check("t9_after_sum", out_sum, 32'd5);
    check("t9_after_valid", {31'd0, out_valid}, 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
